// File: rtl/player_pkg.sv
// player_pkg: shared direction/state encodings and counter width for the player controller
package player_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ATTACK   = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;
    localparam logic [1:0] ST_PAUSED   = 2'd3;

    // Fixed priority among pressed directions: up > right > down > left
    function automatic logic [1:0] dir_sel(input logic up, input logic right, input logic down);
        return up ? DIR_UP : right ? DIR_RIGHT : down ? DIR_DOWN : DIR_LEFT;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// btn_sync: parameterized-width two-flop synchronizer for asynchronous button pins
module btn_sync #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two back-to-back flops to resolve metastability on the raw pins
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/player_action_ctrl.sv
// player_action_ctrl: frame-paced move/attack/pause sequencer; PLAYER_CTRL_SYNC_EN adds button synchronizers
module player_action_ctrl
    import player_pkg::*;
#(
    parameter int ATTACK_FRAMES   = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int MOVE_DIV        = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       A,
    input  logic       B,
    input  logic       start,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic [1:0] facing,
    output logic       attack_start,
    output logic       sword_active,
    output logic       paused
);

    localparam logic [CNT_W-1:0] ATK_LD = CNT_W'(ATTACK_FRAMES - 1);
    localparam logic [CNT_W-1:0] CD_LD  = CNT_W'(COOLDOWN_FRAMES - 1);
    localparam logic [CNT_W-1:0] MV_TOP = CNT_W'(MOVE_DIV - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [6:0] btn_raw;
    logic [6:0] btn;

    assign btn_raw = {start, B, A, left, right, down, up};

`ifdef PLAYER_CTRL_SYNC_EN
    btn_sync #(.W(7)) u_btn_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (btn_raw),
        .q_o    (btn)
    );
`else
    assign btn = btn_raw;
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] atk_cnt_q, atk_cnt_d;
    logic [CNT_W-1:0] move_cnt_q, move_cnt_d;
    logic [1:0]       move_dir_q, move_dir_d;
    logic [1:0]       facing_q, facing_d;
    logic             move_valid_q, move_valid_d;
    logic             attack_start_q, attack_start_d;
    logic             sword_q, sword_d;
    logic             start_q;
    logic             start_edge, atk_req, dir_req;
    logic [1:0]       dir;

    assign start_edge = btn[6] & ~start_q;
    assign atk_req    = btn[5] | btn[4];
    assign dir_req    = |btn[3:0];
    assign dir        = dir_sel(btn[0], btn[2], btn[1]);

    // Next-state: a start edge preempts any same-cycle tick; everything else waits for frame_tick
    always_comb begin
        state_d        = state_q;
        atk_cnt_d      = atk_cnt_q;
        move_cnt_d     = move_cnt_q;
        move_dir_d     = move_dir_q;
        facing_d       = facing_q;
        sword_d        = sword_q;
        move_valid_d   = 1'b0;
        attack_start_d = 1'b0;
        if (start_edge) begin
            if (state_q == ST_PAUSED) begin
                state_d    = ST_IDLE;
                move_cnt_d = MV_TOP;
            end else begin
                state_d   = ST_PAUSED;
                sword_d   = 1'b0;
                atk_cnt_d = '0;
            end
        end else if (frame_tick && state_q != ST_PAUSED) begin
            if (state_q == ST_ATTACK) begin
                state_d   = (atk_cnt_q == '0) ? ST_COOLDOWN : ST_ATTACK;
                atk_cnt_d = (atk_cnt_q == '0) ? CD_LD : atk_cnt_q - ONE;
                sword_d   = (atk_cnt_q != '0);
            end else if (state_q == ST_IDLE && atk_req) begin
                state_d        = ST_ATTACK;
                attack_start_d = 1'b1;
                sword_d        = 1'b1;
                atk_cnt_d      = ATK_LD;
            end else begin
                if (state_q == ST_COOLDOWN) begin
                    state_d   = (atk_cnt_q == '0) ? ST_IDLE : ST_COOLDOWN;
                    atk_cnt_d = (atk_cnt_q == '0) ? '0 : atk_cnt_q - ONE;
                end
                if (dir_req && move_cnt_q == MV_TOP) begin
                    move_valid_d = 1'b1;
                    move_dir_d   = dir;
                    facing_d     = dir;
                    move_cnt_d   = '0;
                end else if (move_cnt_q != MV_TOP) begin
                    move_cnt_d = move_cnt_q + ONE;
                end
            end
        end
    end

    // State, counters and registered command outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            atk_cnt_q      <= '0;
            move_cnt_q     <= MV_TOP;
            move_dir_q     <= DIR_UP;
            facing_q       <= DIR_UP;
            sword_q        <= 1'b0;
            move_valid_q   <= 1'b0;
            attack_start_q <= 1'b0;
            start_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            atk_cnt_q      <= atk_cnt_d;
            move_cnt_q     <= move_cnt_d;
            move_dir_q     <= move_dir_d;
            facing_q       <= facing_d;
            sword_q        <= sword_d;
            move_valid_q   <= move_valid_d;
            attack_start_q <= attack_start_d;
            start_q        <= btn[6];
        end
    end

    assign move_valid   = move_valid_q;
    assign move_dir     = move_dir_q;
    assign facing       = facing_q;
    assign attack_start = attack_start_q;
    assign sword_active = sword_q;
    assign paused       = (state_q == ST_PAUSED);

endmodule

// File: tb/tb_player_action_ctrl.sv
// tb_player_action_ctrl: scoreboard bench for player_action_ctrl (default build)
module tb_player_action_ctrl;

    logic clk = 1'b0, reset = 1'b0, frame_tick = 1'b0;
    logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic A = 1'b0, B = 1'b0, start = 1'b0;
    logic move_valid, attack_start, sword_active, paused;
    logic [1:0] move_dir, facing;

    int n_cmp = 0;
    int n_bad = 0;

    // {mv, dir (masked when no move), attack_start, sword_active, facing, paused}
    typedef struct packed {
        logic       mv;
        logic [1:0] dir;
        logic       as;
        logic       sw;
        logic [1:0] fc;
        logic       pz;
    } obs_t;

    // buttons are {up, right, down, left, A, B}
    typedef struct {
        logic [5:0] b;
        obs_t       e;
    } step_t;

    obs_t sb[$];

    always #5 clk = ~clk;

    player_action_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .up           (up),
        .down         (down),
        .left         (left),
        .right        (right),
        .A            (A),
        .B            (B),
        .start        (start),
        .move_valid   (move_valid),
        .move_dir     (move_dir),
        .facing       (facing),
        .attack_start (attack_start),
        .sword_active (sword_active),
        .paused       (paused)
    );

    function automatic obs_t observe();
        return {move_valid, move_valid ? move_dir : 2'b00, attack_start, sword_active, facing, paused};
    endfunction

    task automatic tick(input logic [5:0] b);
        @(negedge clk);
        {up, right, down, left, A, B} = b;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        sb.push_back(8'b0_00_0_0_00_0);
        got = observe(); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL reset got=%b exp=%b", got, exp); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        sb.push_back(8'b0_00_0_0_00_0);
        got = observe(); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL reset_release got=%b exp=%b", got, exp); end
    endtask

    task automatic test_move_right();
        obs_t got, exp;
        for (int i = 0; i < 4; i++) begin
            sb.push_back((i % 2 == 0) ? 8'b1_01_0_0_01_0 : 8'b0_00_0_0_01_0);
            tick(6'b010000);
            got = observe(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL move_right tick%0d got=%b exp=%b", i + 1, got, exp); end
            if (i == 0) begin
                @(negedge clk);
                n_cmp++;
                if (move_valid !== 1'b0) begin n_bad++; $display("FAIL pulse_width got=%b exp=0", move_valid); end
            end
        end
    endtask

    task automatic test_priority();
        obs_t got, exp;
        step_t st[$];
        st.push_back('{b: 6'b100100, e: 8'b1_00_0_0_00_0});
        st.push_back('{b: 6'b000000, e: 8'b0_00_0_0_00_0});
        st.push_back('{b: 6'b010000, e: 8'b1_01_0_0_01_0});
        foreach (st[i]) begin
            sb.push_back(st[i].e);
            tick(st[i].b);
            got = observe(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL priority step%0d got=%b exp=%b", i, got, exp); end
        end
    endtask

    task automatic test_attack_cooldown();
        obs_t got, exp;
        step_t st[$];
        st.push_back('{b: 6'b000000, e: 8'b0_00_0_0_01_0});
        st.push_back('{b: 6'b000010, e: 8'b0_00_1_1_01_0});
        for (int i = 0; i < 3; i++) st.push_back('{b: 6'b000000, e: 8'b0_00_0_1_01_0});
        st.push_back('{b: 6'b000000, e: 8'b0_00_0_0_01_0});
        for (int i = 1; i <= 8; i++)
            st.push_back('{b: 6'b001010, e: (i % 2 == 1) ? 8'b1_10_0_0_10_0 : 8'b0_00_0_0_10_0});
        st.push_back('{b: 6'b001010, e: 8'b0_00_1_1_10_0});
        foreach (st[i]) begin
            sb.push_back(st[i].e);
            tick(st[i].b);
            got = observe(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL attack_cooldown step%0d got=%b exp=%b", i, got, exp); end
        end
    endtask

    task automatic test_pause();
        obs_t got, exp;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(8'b0_00_0_1_10_0);
            tick(6'b000000);
            got = observe(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL pause_pre step%0d got=%b exp=%b", i, got, exp); end
        end
        @(negedge clk);
        start = 1'b1;
        sb.push_back(8'b0_00_0_0_10_1);
        repeat (3) @(negedge clk);
        got = observe(); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL pause_enter got=%b exp=%b", got, exp); end
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(8'b0_00_0_0_10_1);
            tick(6'b010000);
            got = observe(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL pause_ticks step%0d got=%b exp=%b", i, got, exp); end
        end
        @(negedge clk);
        start = 1'b1;
        sb.push_back(8'b0_00_0_0_10_0);
        repeat (3) @(negedge clk);
        got = observe(); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL pause_exit got=%b exp=%b", got, exp); end
        start = 1'b0;
        sb.push_back(8'b1_01_0_0_01_0);
        tick(6'b010000);
        got = observe(); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL pause_resume_move got=%b exp=%b", got, exp); end
    endtask

    task automatic test_reset_coincide();
        obs_t got, exp;
        step_t st[$];
        st.push_back('{b: 6'b000010, e: 8'b0_00_1_1_01_0});
        for (int i = 0; i < 3; i++) st.push_back('{b: 6'b000000, e: 8'b0_00_0_1_01_0});
        for (int i = 0; i < 3; i++) st.push_back('{b: 6'b000000, e: 8'b0_00_0_0_01_0});
        foreach (st[i]) begin
            sb.push_back(st[i].e);
            tick(st[i].b);
            got = observe(); exp = sb.pop_front(); n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL reset_setup step%0d got=%b exp=%b", i, got, exp); end
        end
        @(negedge clk);
        start = 1'b1;
        frame_tick = 1'b1;
        reset = 1'b0;
        sb.push_back(8'b0_00_0_0_00_0);
        #1;
        got = observe(); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL reset_coincide got=%b exp=%b", got, exp); end
        @(negedge clk);
        frame_tick = 1'b0;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sb.push_back(8'b0_00_1_1_00_0);
        tick(6'b000001);
        got = observe(); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL reset_then_b got=%b exp=%b", got, exp); end
    endtask

    task automatic test_async_reset();
        obs_t got, exp;
        @(negedge clk);
        {up, right, down, left, A, B} = 6'b000000;
        @(negedge clk);
        n_cmp++;
        if (sword_active !== 1'b1) begin n_bad++; $display("FAIL async_pre_sword got=%b exp=1", sword_active); end
        @(posedge clk);
        #2;
        reset = 1'b0;
        sb.push_back(8'b0_00_0_0_00_0);
        #1;
        got = observe(); exp = sb.pop_front(); n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL async_reset got=%b exp=%b", got, exp); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_move_right();
        test_priority();
        test_attack_cooldown();
        test_pause();
        test_reset_coincide();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
